// File: rtl/angledist_sched.sv
// angledist_sched: nearest-match scheduler for an external distance datapath.
// It streams a registered query against up to NREF stored library vectors and
// keeps the smallest returned distance. On a tie the lower library index wins.
module angledist_sched #(
    parameter int DIM  = 6,
    parameter int W    = 16,
    parameter int NREF = 8,
    parameter int LAT  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        lib_we_i,
    input  logic [$clog2(NREF)-1:0]     lib_idx_i,
    input  logic [$clog2(DIM)-1:0]      lib_dim_i,
    input  logic [W-1:0]                lib_data_i,
    input  logic                        q_valid_i,
    output logic                        q_ready_o,
    input  logic [DIM*W-1:0]            q_data_i,
    input  logic [$clog2(NREF):0]       q_nref_i,
    output logic [DIM*W-1:0]            dp_a_o,
    output logic [DIM*W-1:0]            dp_b_o,
    input  logic [W-1:0]                dp_res_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [$clog2(NREF)-1:0]     res_idx_o,
    output logic [W-1:0]                res_dist_o
);

    localparam int IW = $clog2(NREF);
    localparam int DW = $clog2(DIM);
    localparam int NW = IW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    // Query, library and scan bookkeeping
    logic [DIM*W-1:0] query_q;
    logic [DIM*W-1:0] lib_mem [NREF];
    logic [NW-1:0]    n_q;
    logic [NW-1:0]    k_q;
    logic [NW-1:0]    n_clamped;

    // Held datapath operands (shown whenever no pair is being issued)
    logic [DIM*W-1:0] dp_a_q;
    logic [DIM*W-1:0] dp_b_q;

    // In-flight tracking: stage 0 is the newest pair, stage LAT-1 the tail
    logic [LAT-1:0]   pipe_valid;
    logic [IW-1:0]    pipe_idx [LAT];

    // Running best match
    logic [W-1:0]     best_dist;
    logic [IW-1:0]    best_idx;

    // Control strobes
    logic             accept;
    logic             issuing;
    logic             last_issue;
    logic             tail_valid;
    logic             take_better;
    logic             others_busy;

    assign accept      = q_valid_i && (state == IDLE);
    assign issuing     = (state == ISSUE);
    assign last_issue  = ((k_q + 1'b1) == n_q);
    assign tail_valid  = pipe_valid[LAT-1];
    assign take_better = tail_valid && (dp_res_i < best_dist);
    assign n_clamped   = (q_nref_i > NW'(NREF)) ? NW'(NREF) : q_nref_i;

    // True while any pair other than the tail entry is still in flight
    always_comb begin
        others_busy = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            others_busy = others_busy | pipe_valid[i];
        end
    end

    // State register; reset wins over every handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode: scan the library, wait for the tail, then hold the result
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (n_clamped != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!others_busy) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs come straight from the state; the result mirrors the best registers
    assign q_ready_o   = (state == IDLE);
    assign res_valid_o = (state == DONE);
    assign res_idx_o   = best_idx;
    assign res_dist_o  = best_dist;

    // The issued pair is visible in its own cycle; otherwise the last pair is held
    assign dp_a_o = issuing ? query_q : dp_a_q;
    assign dp_b_o = issuing ? lib_mem[k_q[IW-1:0]] : dp_b_q;

    // Library element writes, only while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREF; k++) begin
                lib_mem[k] <= '0;
            end
        end else if (lib_we_i && (state == IDLE)) begin
            for (int k = 0; k < NREF; k++) begin
                for (int d = 0; d < DIM; d++) begin
                    if ((lib_idx_i == IW'(k)) && (lib_dim_i == DW'(d))) begin
                        lib_mem[k][d*W +: W] <= lib_data_i;
                    end
                end
            end
        end
    end

    // Query capture, scan length and issue counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            query_q <= '0;
            n_q     <= '0;
            k_q     <= '0;
        end else if (accept) begin
            query_q <= q_data_i;
            n_q     <= n_clamped;
            k_q     <= '0;
        end else if (issuing) begin
            k_q     <= k_q + 1'b1;
        end
    end

    // Remember the last issued operands so the datapath inputs hold between scans
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dp_a_q <= '0;
            dp_b_q <= '0;
        end else if (issuing) begin
            dp_a_q <= query_q;
            dp_b_q <= lib_mem[k_q[IW-1:0]];
        end
    end

    // Shift the {valid, idx} tags alongside the datapath so results can be attributed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issuing;
            pipe_idx[0]   <= k_q[IW-1:0];
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_idx[i]   <= pipe_idx[i-1];
            end
        end
    end

    // Track the minimum distance; strict compare keeps the earliest index on ties
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            best_dist <= '1;
            best_idx  <= '0;
        end else if (accept) begin
            best_dist <= '1;
            best_idx  <= '0;
        end else if (take_better) begin
            best_dist <= dp_res_i;
            best_idx  <= pipe_idx[LAT-1];
        end
    end

endmodule

// File: tb/tb_angledist_sched.sv
// Directed bench for angledist_sched with a behavioural LAT-cycle distance datapath.
module tb_angledist_sched;

    localparam int DIM  = 6;
    localparam int W    = 16;
    localparam int NREF = 8;
    localparam int LAT  = 2;
    localparam int IW   = 3;
    localparam int DW   = 3;
    localparam int NW   = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              lib_we_i = 1'b0;
    logic [IW-1:0]     lib_idx_i = '0;
    logic [DW-1:0]     lib_dim_i = '0;
    logic [W-1:0]      lib_data_i = '0;
    logic              q_valid_i = 1'b0;
    logic              q_ready_o;
    logic [DIM*W-1:0]  q_data_i = '0;
    logic [NW-1:0]     q_nref_i = '0;
    logic [DIM*W-1:0]  dp_a_o;
    logic [DIM*W-1:0]  dp_b_o;
    logic [W-1:0]      dp_res_i;
    logic              res_valid_o;
    logic              res_ready_i = 1'b1;
    logic [IW-1:0]     res_idx_o;
    logic [W-1:0]      res_dist_o;

    int vecCount = 0;
    int errCount = 0;
    int dpMode   = 0;

    logic [W-1:0] dpPipe [LAT] = '{default: '0};

    always #5 clk_i = ~clk_i;

    angledist_sched #(
        .DIM (DIM),
        .W   (W),
        .NREF(NREF),
        .LAT (LAT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .lib_we_i   (lib_we_i),
        .lib_idx_i  (lib_idx_i),
        .lib_dim_i  (lib_dim_i),
        .lib_data_i (lib_data_i),
        .q_valid_i  (q_valid_i),
        .q_ready_o  (q_ready_o),
        .q_data_i   (q_data_i),
        .q_nref_i   (q_nref_i),
        .dp_a_o     (dp_a_o),
        .dp_b_o     (dp_b_o),
        .dp_res_i   (dp_res_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_idx_o  (res_idx_o),
        .res_dist_o (res_dist_o)
    );

    // Library element k, dim d: distinct per entry; entry 3 equals the query
    function automatic logic [W-1:0] refVal(input int k, input int d);
        return W'(32'h1000 + k * 16 + d);
    endfunction

    function automatic logic [DIM*W-1:0] refVec(input int k);
        logic [DIM*W-1:0] v;
        for (int d = 0; d < DIM; d++) v[d*W +: W] = refVal(k, d);
        return v;
    endfunction

    function automatic logic [DIM*W-1:0] queryVec();
        return refVec(3);
    endfunction

    // Mode 0: 0 on exact match, else 100 + library index; mode 1: constant 0x0040
    function automatic logic [W-1:0] dpModel(input logic [DIM*W-1:0] a, input logic [DIM*W-1:0] b);
        logic [W-1:0] e0;
        if (dpMode == 1) return 16'h0040;
        if (a == b) return 16'h0000;
        e0 = b[W-1:0] - 16'h1000;
        return 16'd100 + (e0 >> 4);
    endfunction

    // Behavioural datapath: result appears LAT cycles after the operands
    always @(posedge clk_i) begin
        dpPipe[0] <= dpModel(dp_a_o, dp_b_o);
        for (int i = 1; i < LAT; i++) dpPipe[i] <= dpPipe[i-1];
    end
    assign dp_res_i = dpPipe[LAT-1];

    task automatic loadLib();
        for (int k = 0; k < NREF; k++) begin
            for (int d = 0; d < DIM; d++) begin
                lib_we_i   = 1'b1;
                lib_idx_i  = IW'(k);
                lib_dim_i  = DW'(d);
                lib_data_i = refVal(k, d);
                @(negedge clk_i);
            end
        end
        lib_we_i = 1'b0;
    endtask

    // Presents a query for one cycle (t) and returns at the negedge of cycle t+1
    task automatic applyStimulus(input int nref);
        q_data_i  = queryVec();
        q_nref_i  = NW'(nref);
        q_valid_i = 1'b1;
        @(negedge clk_i);
        q_valid_i = 1'b0;
    endtask

    // Counts cycles after accept until res_valid_o, bounded at 40
    task automatic waitResult(input int start, output int lat);
        lat = start;
        while (res_valid_o !== 1'b1 && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_i      = 1'b1;
        lib_we_i   = 1'b1;
        lib_idx_i  = '0;
        lib_dim_i  = '0;
        lib_data_i = 16'hFFFF;
        q_valid_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        vecCount++; if (q_ready_o !== 1'b1) begin errCount++; $display("[TB] FAIL reset_q_ready got %b want 1", q_ready_o); end
        vecCount++; if (res_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL reset_res_valid got %b want 0", res_valid_o); end
        vecCount++; if (res_idx_o !== 3'd0) begin errCount++; $display("[TB] FAIL reset_res_idx got %0d want 0", res_idx_o); end
        vecCount++; if (res_dist_o !== 16'hFFFF) begin errCount++; $display("[TB] FAIL reset_res_dist got %h want ffff", res_dist_o); end
        vecCount++; if (dp_a_o !== '0) begin errCount++; $display("[TB] FAIL reset_dp_a got %h want 0", dp_a_o); end
        vecCount++; if (dp_b_o !== '0) begin errCount++; $display("[TB] FAIL reset_dp_b got %h want 0", dp_b_o); end
        rst_i     = 1'b0;
        lib_we_i  = 1'b0;
        q_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_single_match();
        int lat;
        dpMode      = 0;
        res_ready_i = 1'b1;
        loadLib();
        applyStimulus(8);
        waitResult(1, lat);
        vecCount++; if (lat != 11) begin errCount++; $display("[TB] FAIL single_latency got t+%0d want t+11", lat); end
        vecCount++; if (res_idx_o !== 3'd3) begin errCount++; $display("[TB] FAIL single_idx got %0d want 3", res_idx_o); end
        vecCount++; if (res_dist_o !== 16'h0000) begin errCount++; $display("[TB] FAIL single_dist got %h want 0000", res_dist_o); end
        @(negedge clk_i);
        vecCount++; if (q_ready_o !== 1'b1) begin errCount++; $display("[TB] FAIL single_back_idle got %b want 1", q_ready_o); end
        vecCount++; if (res_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL single_valid_drop got %b want 0", res_valid_o); end
    endtask

    task automatic test_tie();
        int lat;
        dpMode = 1;
        applyStimulus(8);
        waitResult(1, lat);
        vecCount++; if (lat != 11) begin errCount++; $display("[TB] FAIL tie_latency got t+%0d want t+11", lat); end
        vecCount++; if (res_idx_o !== 3'd0) begin errCount++; $display("[TB] FAIL tie_idx got %0d want 0", res_idx_o); end
        vecCount++; if (res_dist_o !== 16'h0040) begin errCount++; $display("[TB] FAIL tie_dist got %h want 0040", res_dist_o); end
        @(negedge clk_i);
        dpMode = 0;
    endtask

    task automatic test_zero_count();
        logic [DIM*W-1:0] prevB;
        prevB = dp_b_o;
        applyStimulus(0);
        vecCount++; if (res_valid_o !== 1'b1) begin errCount++; $display("[TB] FAIL zero_valid_t1 got %b want 1", res_valid_o); end
        vecCount++; if (res_idx_o !== 3'd0) begin errCount++; $display("[TB] FAIL zero_idx got %0d want 0", res_idx_o); end
        vecCount++; if (res_dist_o !== 16'hFFFF) begin errCount++; $display("[TB] FAIL zero_dist got %h want ffff", res_dist_o); end
        vecCount++; if (dp_b_o !== prevB) begin errCount++; $display("[TB] FAIL zero_dp_b got %h want %h", dp_b_o, prevB); end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        int lat;
        dpMode      = 0;
        res_ready_i = 1'b0;
        applyStimulus(8);
        waitResult(1, lat);
        vecCount++; if (lat != 11) begin errCount++; $display("[TB] FAIL bp_latency got t+%0d want t+11", lat); end
        for (int c = 0; c < 5; c++) begin
            lib_we_i   = 1'b1;
            lib_idx_i  = 3'd3;
            lib_dim_i  = 3'd0;
            lib_data_i = 16'hDEAD;
            q_valid_i  = 1'b1;
            q_nref_i   = 4'd1;
            @(negedge clk_i);
            vecCount++; if (res_valid_o !== 1'b1) begin errCount++; $display("[TB] FAIL bp_valid_hold c%0d got %b want 1", c, res_valid_o); end
            vecCount++; if (q_ready_o !== 1'b0) begin errCount++; $display("[TB] FAIL bp_q_ready c%0d got %b want 0", c, q_ready_o); end
            vecCount++; if (res_idx_o !== 3'd3) begin errCount++; $display("[TB] FAIL bp_idx_hold c%0d got %0d want 3", c, res_idx_o); end
            vecCount++; if (res_dist_o !== 16'h0000) begin errCount++; $display("[TB] FAIL bp_dist_hold c%0d got %h want 0000", c, res_dist_o); end
        end
        lib_we_i    = 1'b0;
        q_valid_i   = 1'b0;
        res_ready_i = 1'b1;
        @(negedge clk_i);
        vecCount++; if (q_ready_o !== 1'b1) begin errCount++; $display("[TB] FAIL bp_release got %b want 1", q_ready_o); end
        vecCount++; if (res_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL bp_valid_drop got %b want 0", res_valid_o); end
    endtask

    task automatic test_clamp();
        int lat;
        dpMode = 0;
        applyStimulus(12);
        for (int k = 0; k < 8; k++) begin
            vecCount++; if (dp_b_o !== refVec(k)) begin errCount++; $display("[TB] FAIL clamp_dp_b k%0d got %h want %h", k, dp_b_o, refVec(k)); end
            vecCount++; if (dp_a_o !== queryVec()) begin errCount++; $display("[TB] FAIL clamp_dp_a k%0d got %h want %h", k, dp_a_o, queryVec()); end
            @(negedge clk_i);
        end
        vecCount++; if (dp_b_o !== refVec(7)) begin errCount++; $display("[TB] FAIL clamp_dp_b_hold got %h want %h", dp_b_o, refVec(7)); end
        waitResult(9, lat);
        vecCount++; if (lat != 11) begin errCount++; $display("[TB] FAIL clamp_latency got t+%0d want t+11", lat); end
        vecCount++; if (res_idx_o !== 3'd3) begin errCount++; $display("[TB] FAIL clamp_idx got %0d want 3", res_idx_o); end
        vecCount++; if (res_dist_o !== 16'h0000) begin errCount++; $display("[TB] FAIL clamp_dist got %h want 0000", res_dist_o); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_midscan();
        int lat;
        logic pulseSeen;
        dpMode = 0;
        applyStimulus(8);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        vecCount++; if (q_ready_o !== 1'b1) begin errCount++; $display("[TB] FAIL midrst_q_ready got %b want 1", q_ready_o); end
        vecCount++; if (dp_b_o !== '0) begin errCount++; $display("[TB] FAIL midrst_dp_b got %h want 0", dp_b_o); end
        pulseSeen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            pulseSeen = pulseSeen | res_valid_o;
            @(negedge clk_i);
        end
        vecCount++; if (pulseSeen !== 1'b0) begin errCount++; $display("[TB] FAIL midrst_no_pulse got %b want 0", pulseSeen); end
        vecCount++; if (res_dist_o !== 16'hFFFF) begin errCount++; $display("[TB] FAIL midrst_dist_ignored got %h want ffff", res_dist_o); end
        loadLib();
        applyStimulus(8);
        waitResult(1, lat);
        vecCount++; if (lat != 11) begin errCount++; $display("[TB] FAIL midrst_rerun_latency got t+%0d want t+11", lat); end
        vecCount++; if (res_idx_o !== 3'd3) begin errCount++; $display("[TB] FAIL midrst_rerun_idx got %0d want 3", res_idx_o); end
        vecCount++; if (res_dist_o !== 16'h0000) begin errCount++; $display("[TB] FAIL midrst_rerun_dist got %h want 0000", res_dist_o); end
        @(negedge clk_i);
    endtask

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single_match();
        test_tie();
        test_zero_count();
        test_back_to_back();
        test_clamp();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/angledist_sched.md
ANGLEDIST_SCHED -- requirements
Module: angledist_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DIM, 6, vector elements per comparison.
- W, 16, element and distance width in bits.
- NREF, 8, library depth in vectors.
- LAT, 2, datapath latency in cycles from dp_*_o to dp_res_i.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, the single clock.
- rst_i, in, 1, synchronous active-high reset.
- lib_we_i, in, 1, library element write strobe.
- lib_idx_i, in, clog2(NREF), library vector index.
- lib_dim_i, in, clog2(DIM), element index.
- lib_data_i, in, W, element value.
- q_valid_i, in, 1, query valid.
- q_ready_o, out, 1, query ready.
- q_data_i, in, DIM*W, query vector; element i is at [i*W +: W].
- q_nref_i, in, clog2(NREF)+1, number of library vectors to scan.
- dp_a_o, out, DIM*W, query operand to the datapath.
- dp_b_o, out, DIM*W, library operand to the datapath.
- dp_res_i, in, W, datapath distance result.
- res_valid_o, out, 1, result valid.
- res_ready_i, in, 1, result ready.
- res_idx_o, out, clog2(NREF), index of the best match.
- res_dist_o, out, W, distance of the best match.

Function
REQ-003 The block SHALL have one clock domain; reset SHALL be synchronous and active-high on rst_i, sampled at the rising edge of clk_i.
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, DRAIN, DONE; q_ready_o SHALL be 1 only in IDLE.
REQ-005 Library writes SHALL be accepted only in IDLE and SHALL be ignored in all other states: ref[lib_idx_i][lib_dim_i] <= lib_data_i.
REQ-006 On query accept (q_valid_i && q_ready_o):
- q_data_i SHALL be registered into the query register.
- n = min(q_nref_i, NREF) SHALL be registered.
- best_dist SHALL be set to all-ones and best_idx to 0.
- The next state SHALL be ISSUE if n>0, else DONE.
REQ-007 In ISSUE, one pair SHALL be issued per cycle: dp_a_o = query, dp_b_o = ref[k], for k = 0..n-1. The state SHALL go to DRAIN after issuing k=n-1.
REQ-008 Outside ISSUE, dp_a_o and dp_b_o SHALL hold their last values; the datapath has no valid input.
REQ-009 A LAT-deep shift register of {valid, idx} SHALL track in-flight pairs; dp_res_i SHALL be consumed only in the cycle the tail entry is valid.
REQ-010 On a consumed result, if dp_res_i < best_dist (unsigned, strict), best_dist and best_idx SHALL update; ties SHALL keep the lower index.
REQ-011 DRAIN SHALL go to DONE in the cycle after the last in-flight result is consumed.
REQ-012 In DONE:
- res_valid_o SHALL be 1, with res_idx_o = best_idx and res_dist_o = best_dist.
- The outputs SHALL hold stable until res_valid_o && res_ready_i, after which the state SHALL go to IDLE.
REQ-013 Latency: with accept in cycle t, issues occupy cycles t+1..t+n and res_valid_o SHALL first assert in cycle t+n+LAT+1; with n=0 it SHALL assert in cycle t+1.
REQ-014 A new query SHALL NOT be accepted until the result handshake completes; no pipelining across queries.
REQ-015 res_idx_o and res_dist_o SHALL be don't-care while res_valid_o=0 but SHALL be driven from the best_* registers at all times.

Reset
REQ-016 Reset SHALL force:
- state = IDLE, q_ready_o = 1, res_valid_o = 0;
- best_idx = 0, best_dist = all-ones;
- all pipeline valid bits = 0;
- query and library registers = 0;
- dp_a_o = 0 and dp_b_o = 0.
REQ-017 Reset asserted mid-scan SHALL abort the scan; results returning on dp_res_i afterwards SHALL be ignored and no result SHALL be produced.
REQ-018 Reset SHALL take priority over lib_we_i and over any handshake in the same cycle.

Verification
REQ-019 The bench SHALL cover the following directed scenarios.
- Single match: load ref[3]=query and all other refs distinct; model returns 0 for an exact match and 100+idx otherwise; n=8, LAT=2. Required: res_idx_o=3, res_dist_o=0, res_valid_o first high in cycle t+11.
- Tie: all results 0x0040. Required: res_idx_o=0, res_dist_o=0x0040.
- Zero count: q_nref_i=0. Required: res_valid_o in cycle t+1, res_idx_o=0, res_dist_o=0xFFFF, no dp_b_o change.
- Backpressure and clamping: hold res_ready_i=0 for 5 cycles. Required: outputs stable, q_ready_o=0, lib writes ignored (readback in the next scan unchanged). Then q_nref_i=12 with NREF=8. Required: exactly 8 issues.
- Reset mid-scan: assert rst_i in the 3rd ISSUE cycle. Required: next cycle IDLE, q_ready_o=1, no res_valid_o pulse over the following 10 cycles; a new query then completes normally.
